// File: rtl/rc4_decrypt.sv
// RC4 keystream generation and decryption stage (PRGA).
// Walks the already-shuffled S memory, swaps S[i]/S[j] in place, XORs each keystream byte with
// the matching encrypted-ROM byte and writes the plaintext to the decrypted-message RAM.
// Optionally aborts on the first plaintext byte outside 'a'..'z' / space.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 single-cycle request, accepted only in IDLE or DONE
//   done, fail            completion level and invalid-plaintext flag (fail valid while done)
//   s_address/s_data/s_wren/s_q   S memory port (1-cycle synchronous read)
//   rom_address/rom_q             encrypted ROM port (1-cycle synchronous read)
//   ram_address/ram_data/ram_wren decrypted RAM write port
module rc4_decrypt #(
    parameter int unsigned MSG_LEN  = 32,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       fail,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_q,
    output logic [7:0] ram_address,
    output logic [7:0] ram_data,
    output logic       ram_wren
);

    typedef enum logic [3:0] {
        StIdle, StRdI, StWtI, StLdI, StRdJ, StWtJ, StLdJ, StWrI, StWrJ,
        StRdF, StWtF, StLdF, StWrOut, StNext, StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;
    logic [8:0] k_q, k_d;
    logic       done_q, done_d, fail_q, fail_d;
    logic [7:0] s_address_q, s_address_d, s_data_q, s_data_d;
    logic       s_wren_q, s_wren_d;
    logic [7:0] rom_address_q, rom_address_d, ram_address_q, ram_address_d;
    logic       ram_wren_q, ram_wren_d;

    function automatic logic is_text(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    // Memory-facing outputs are registered and loaded on the transition into the state that
    // uses them, so they are stable for the whole RD/WT/LD window of each access.
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        si_d          = si_q;
        sj_d          = sj_q;
        f_d           = f_q;
        enc_d         = enc_q;
        k_d           = k_q;
        done_d        = done_q;
        fail_d        = fail_q;
        s_address_d   = s_address_q;
        s_data_d      = s_data_q;
        s_wren_d      = 1'b0;
        rom_address_d = rom_address_q;
        ram_address_d = ram_address_q;
        ram_wren_d    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                // done lags entry into DONE by one cycle
                done_d = (state_q == StDone);
                if (start) begin
                    i_d         = 8'd1;
                    j_d         = 8'd0;
                    k_d         = 9'd0;
                    fail_d      = 1'b0;
                    done_d      = 1'b0;
                    s_address_d = 8'd1;
                    state_d     = StRdI;
                end
            end
            StRdI: state_d = StWtI;
            StWtI: state_d = StLdI;
            StLdI: begin
                si_d        = s_q;
                j_d         = j_q + s_q;
                s_address_d = j_q + s_q;
                state_d     = StRdJ;
            end
            StRdJ: state_d = StWtJ;
            StWtJ: state_d = StLdJ;
            StLdJ: begin
                sj_d        = s_q;
                s_address_d = i_q;
                s_data_d    = s_q;
                s_wren_d    = 1'b1;
                state_d     = StWrI;
            end
            StWrI: begin
                // when i == j this second write lands on the same cell with si, the original
                s_address_d = j_q;
                s_data_d    = si_q;
                s_wren_d    = 1'b1;
                state_d     = StWrJ;
            end
            StWrJ: begin
                s_address_d   = si_q + sj_q;
                rom_address_d = k_q[7:0];
                state_d       = StRdF;
            end
            StRdF: state_d = StWtF;
            StWtF: state_d = StLdF;
            StLdF: begin
                f_d           = s_q;
                enc_d         = rom_q;
                ram_address_d = k_q[7:0];
                ram_wren_d    = 1'b1;
                state_d       = StWrOut;
            end
            StWrOut: begin
                if (CHECK_EN && !is_text(f_q ^ enc_q)) begin
                    fail_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (k_q == 9'(MSG_LEN - 1)) begin
                    state_d = StDone;
                end else begin
                    k_d         = k_q + 9'd1;
                    i_d         = i_q + 8'd1;
                    s_address_d = i_q + 8'd1;
                    state_d     = StRdI;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            i_q           <= 8'd0;
            j_q           <= 8'd0;
            si_q          <= 8'd0;
            sj_q          <= 8'd0;
            f_q           <= 8'd0;
            enc_q         <= 8'd0;
            k_q           <= 9'd0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            s_address_q   <= 8'd0;
            s_data_q      <= 8'd0;
            s_wren_q      <= 1'b0;
            rom_address_q <= 8'd0;
            ram_address_q <= 8'd0;
            ram_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            si_q          <= si_d;
            sj_q          <= sj_d;
            f_q           <= f_d;
            enc_q         <= enc_d;
            k_q           <= k_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            s_address_q   <= s_address_d;
            s_data_q      <= s_data_d;
            s_wren_q      <= s_wren_d;
            rom_address_q <= rom_address_d;
            ram_address_q <= ram_address_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

    assign done        = done_q;
    assign fail        = fail_q;
    assign s_address   = s_address_q;
    assign s_data      = s_data_q;
    assign s_wren      = s_wren_q;
    assign rom_address = rom_address_q;
    assign ram_address = ram_address_q;
    // f and enc hold from LD_F onward, so the XOR is stable through WR_OUT
    assign ram_data    = f_q ^ enc_q;
    assign ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_rc4_decrypt.sv
// Scoreboard bench for rc4_decrypt: two instances (CHECK_EN off / on) with behavioural S, ROM
// and RAM memories. Drivers push expected RAM writes and done records; monitors pop and compare.
module tb_rc4_decrypt;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // channel A: CHECK_EN = 0, channel B: CHECK_EN = 1
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       done_a, fail_a, s_wren_a, ram_wren_a;
    logic       done_b, fail_b, s_wren_b, ram_wren_b;
    logic [7:0] s_address_a, s_data_a, s_q_a, rom_address_a, rom_q_a, ram_address_a, ram_data_a;
    logic [7:0] s_address_b, s_data_b, s_q_b, rom_address_b, rom_q_b, ram_address_b, ram_data_b;

    rc4_decrypt #(.MSG_LEN(4), .CHECK_EN(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .done(done_a), .fail(fail_a),
        .s_address(s_address_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
        .rom_address(rom_address_a), .rom_q(rom_q_a),
        .ram_address(ram_address_a), .ram_data(ram_data_a), .ram_wren(ram_wren_a)
    );

    rc4_decrypt #(.MSG_LEN(4), .CHECK_EN(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .done(done_b), .fail(fail_b),
        .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
        .rom_address(rom_address_b), .rom_q(rom_q_b),
        .ram_address(ram_address_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b)
    );

    // Memory models
    logic [7:0] s_init [256];
    logic [7:0] rom_init [256];
    logic       load_a = 1'b0, load_b = 1'b0;
    logic [7:0] s_mem_a [256], rom_a [256], ram_a [256];
    logic [7:0] s_mem_b [256], rom_b [256], ram_b [256];

    always @(posedge clk) begin
        if (load_a) begin
            s_mem_a <= s_init;
            rom_a   <= rom_init;
            for (int x = 0; x < 256; x++) ram_a[x] <= 8'hEE;
        end else begin
            if (s_wren_a) s_mem_a[s_address_a] <= s_data_a;
            if (ram_wren_a) ram_a[ram_address_a] <= ram_data_a;
        end
        s_q_a   <= s_mem_a[s_address_a];
        rom_q_a <= rom_a[rom_address_a];
    end

    always @(posedge clk) begin
        if (load_b) begin
            s_mem_b <= s_init;
            rom_b   <= rom_init;
            for (int x = 0; x < 256; x++) ram_b[x] <= 8'hEE;
        end else begin
            if (s_wren_b) s_mem_b[s_address_b] <= s_data_b;
            if (ram_wren_b) ram_b[ram_address_b] <= ram_data_b;
        end
        s_q_b   <= s_mem_b[s_address_b];
        rom_q_b <= rom_b[rom_address_b];
    end

    // Scoreboard
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    typedef struct {
        int lat;
        bit fail;
    } done_t;

    wr_t   wq_a [$];
    wr_t   wq_b [$];
    done_t dq_a [$];
    done_t dq_b [$];
    int    t0_a = 0, t0_b = 0;
    int    swr_b = 0;
    logic  done_a_prev = 1'b0, done_b_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t   w;
        done_t d;
        if (ram_wren_a) begin
            if (wq_a.size() == 0) chk("a_unexpected_ram_write", {24'd0, ram_address_a}, 32'hFFFF);
            else begin
                w = wq_a.pop_front();
                chk("a_ram_addr", {24'd0, ram_address_a}, {24'd0, w.addr});
                chk("a_ram_data", {24'd0, ram_data_a}, {24'd0, w.data});
            end
        end
        if (done_a && !done_a_prev) begin
            if (dq_a.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
            else begin
                d = dq_a.pop_front();
                chk("a_done_latency", cyc - t0_a, d.lat);
                chk("a_fail", {31'd0, fail_a}, {31'd0, d.fail});
            end
        end
        done_a_prev = done_a;
    end

    always @(negedge clk) begin
        wr_t   w;
        done_t d;
        if (s_wren_b) swr_b++;
        if (ram_wren_b) begin
            if (wq_b.size() == 0) chk("b_unexpected_ram_write", {24'd0, ram_address_b}, 32'hFFFF);
            else begin
                w = wq_b.pop_front();
                chk("b_ram_addr", {24'd0, ram_address_b}, {24'd0, w.addr});
                chk("b_ram_data", {24'd0, ram_data_b}, {24'd0, w.data});
            end
        end
        if (done_b && !done_b_prev) begin
            if (dq_b.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
            else begin
                d = dq_b.pop_front();
                chk("b_done_latency", cyc - t0_b, d.lat);
                chk("b_fail", {31'd0, fail_b}, {31'd0, d.fail});
            end
        end
        done_b_prev = done_b;
    end

    // Driver helpers
    task automatic load(input int ch, input bit wrap, input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] r3);
        for (int x = 0; x < 256; x++) begin
            s_init[x]   = 8'(x);
            rom_init[x] = 8'h00;
        end
        if (wrap) begin
            s_init[8'h01] = 8'hF0;
            s_init[8'hF0] = 8'h20;
        end
        rom_init[0] = r0;
        rom_init[1] = r1;
        rom_init[2] = r2;
        rom_init[3] = r3;
        @(negedge clk);
        if (ch == 0) load_a = 1'b1; else load_b = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic expect_run(input int ch, input int n, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3, input int lat,
                              input bit f);
        logic [7:0] d [4];
        done_t      r;
        d = '{d0, d1, d2, d3};
        for (int x = 0; x < n; x++) begin
            if (ch == 0) wq_a.push_back({8'(x), d[x]});
            else wq_b.push_back({8'(x), d[x]});
        end
        if (lat > 0) begin
            r.lat  = lat;
            r.fail = f;
            if (ch == 0) dq_a.push_back(r); else dq_b.push_back(r);
        end
    endtask

    // Returns at the negedge just after the edge that sampled start.
    task automatic pulse_start(input int ch, input bit track);
        @(negedge clk);
        if (ch == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        if (track) begin
            if (ch == 0) t0_a = cyc; else t0_b = cyc;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int ch);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = (ch == 0) ? done_a : done_b;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout ch%0d: got done=0 required done=1 within 300 cycles", ch);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_fail", {31'd0, fail_b}, 32'd0);
        chk("rst_wrens", {30'd0, s_wren_a, ram_wren_b}, 32'd0);
        chk("rst_s_address", {24'd0, s_address_b}, 32'd0);
        chk("rst_ram_addr_data", {16'd0, ram_address_a, ram_data_a}, 32'd0);
        chk("rst_rom_address", {24'd0, rom_address_a}, 32'd0);

        // Keystream with identity S, zero ROM
        load(0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        expect_run(0, 4, 8'h02, 8'h05, 8'h07, 8'h0D, 53, 1'b0);
        pulse_start(0, 1'b1);
        wait_done(0);
        chk("ks_S2", {24'd0, s_mem_a[2]}, 32'h03);
        chk("ks_S3", {24'd0, s_mem_a[3]}, 32'h05);
        chk("ks_S4", {24'd0, s_mem_a[4]}, 32'h09);
        chk("ks_S5", {24'd0, s_mem_a[5]}, 32'h02);
        chk("ks_S9", {24'd0, s_mem_a[9]}, 32'h04);
        chk("ks_ram3", {24'd0, ram_a[3]}, 32'h0D);

        // Valid plaintext, with an ignored start during RD_J of byte 0
        load(1, 1'b0, 8'h63, 8'h67, 8'h27, 8'h77);
        expect_run(1, 4, 8'h61, 8'h62, 8'h20, 8'h7A, 53, 1'b0);
        pulse_start(1, 1'b1);
        repeat (3) @(posedge clk);
        pulse_start(1, 1'b0);
        wait_done(1);

        // Abort at byte 1
        load(1, 1'b0, 8'h63, 8'h00, 8'h27, 8'h77);
        expect_run(1, 2, 8'h61, 8'h05, 8'h00, 8'h00, 26, 1'b1);
        swr_b = 0;
        pulse_start(1, 1'b1);
        wait_done(1);
        repeat (5) @(negedge clk);
        chk("abort_ram1", {24'd0, ram_b[1]}, 32'h05);
        chk("abort_ram2_untouched", {24'd0, ram_b[2]}, 32'hEE);
        chk("abort_ram3_untouched", {24'd0, ram_b[3]}, 32'hEE);
        chk("abort_s_writes", swr_b, 32'd4);
        chk("abort_fail_held", {31'd0, fail_b}, 32'd1);

        // Restart from DONE clears done and fail, full run again
        load(1, 1'b0, 8'h63, 8'h67, 8'h27, 8'h77);
        expect_run(1, 4, 8'h61, 8'h62, 8'h20, 8'h7A, 53, 1'b0);
        pulse_start(1, 1'b1);
        chk("restart_done_cleared", {31'd0, done_b}, 32'd0);
        chk("restart_fail_cleared", {31'd0, fail_b}, 32'd0);
        wait_done(1);

        // Wraparound: j = F0, f index 0x110 -> 0x10
        load(0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        expect_run(0, 4, 8'h10, 8'hF4, 8'hF8, 8'hFD, 53, 1'b0);
        pulse_start(0, 1'b1);
        wait_done(0);
        chk("wrap_S1", {24'd0, s_mem_a[8'h01]}, 32'h20);
        chk("wrap_SF0", {24'd0, s_mem_a[8'hF0]}, 32'hF0);

        // Reset during WR_J of byte 1 (cycle 20 after the start edge)
        load(0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        expect_run(0, 1, 8'h02, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        pulse_start(0, 1'b1);
        repeat (20) @(negedge clk);
        chk("wrj_s_wren", {31'd0, s_wren_a}, 32'd1);
        chk("wrj_s_addr_data", {16'd0, s_address_a, s_data_a}, 32'h0302);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_wrens", {30'd0, s_wren_a, ram_wren_a}, 32'd0);
        chk("midrst_done", {31'd0, done_a}, 32'd0);
        chk("midrst_queue_drained", wq_a.size(), 32'd0);
        load(0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        expect_run(0, 4, 8'h02, 8'h05, 8'h07, 8'h0D, 53, 1'b0);
        pulse_start(0, 1'b1);
        wait_done(0);

        repeat (3) @(negedge clk);
        chk("end_wq_a_empty", wq_a.size() + dq_a.size(), 32'd0);
        chk("end_wq_b_empty", wq_b.size() + dq_b.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
